// File: rtl/mux4_rr_arbiter_if.sv
// Shared channel between four requesters, the arbiter and one downstream consumer.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;

    modport slave (
        input  req,
        input  in_data,
        output in_ready,
        output gnt,
        output sel,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output req,
        output in_data,
        input  in_ready,
        input  gnt,
        input  sel,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter owning a 4:1 data mux, with valid/ready flow control
// and a per-grant burst limit. One idle bubble separates consecutive grants.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_sel;
    logic [3:0] r_gnt;
    logic [7:0] r_count;

    state_t     w_state_nxt;
    logic [1:0] w_ptr_nxt;
    logic [1:0] w_sel_nxt;
    logic [3:0] w_gnt_nxt;
    logic [7:0] w_count_nxt;

    logic [2:0] w_pick;
    logic       w_req_sel;
    logic       w_xfer;
    logic       w_release;

    // Returns {found, index} of the first set request at or after ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_pick    = rr_pick(bus.req, r_ptr);
    assign w_req_sel = bus.req[r_sel];
    assign w_xfer    = (r_state == ST_BUSY) && w_req_sel && bus.out_ready;
    assign w_release = (r_state == ST_BUSY) &&
                       (!w_req_sel || (w_xfer && (r_count == LAST_BEAT)));

    // State register: reset wins mid-burst and drops any in-flight grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic: grant on any request in IDLE, release on req drop or burst end.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[2]) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_pick[1:0];
                    w_gnt_nxt   = 4'b0001 << w_pick[1:0];
                    w_count_nxt = 8'd0;
                end else begin
                    w_gnt_nxt   = 4'b0000;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    // sel is kept so out_data stays in_data[sel] through the bubble.
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_count_nxt = 8'd0;
                end else if (w_xfer) begin
                    w_count_nxt = r_count + 8'd1;
                end else begin
                    w_count_nxt = r_count;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_count_nxt = 8'd0;
            end
        endcase
    end

    // Output logic: mux steering and handshake derived from the registered grant.
    always_comb begin
        bus.out_data  = bus.in_data[r_sel*WIDTH +: WIDTH];
        bus.gnt       = r_gnt;
        bus.sel       = r_sel;
        bus.out_valid = 1'b0;
        bus.in_ready  = 4'b0000;
        case (r_state)
            ST_BUSY: begin
                bus.out_valid = w_req_sel;
                bus.in_ready  = r_gnt & {4{bus.out_ready}};
            end
            ST_IDLE: begin
                bus.out_valid = 1'b0;
                bus.in_ready  = 4'b0000;
            end
            default: begin
                bus.out_valid = 1'b0;
                bus.in_ready  = 4'b0000;
            end
        endcase
    end

    mux4_rr_arbiter_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .busy     (r_state == ST_BUSY),
        .gnt      (r_gnt),
        .sel      (r_sel),
        .in_ready (bus.in_ready)
    );
endmodule

// Structural invariants of the arbiter: one-hot grant only while busy, matching select.
module mux4_rr_arbiter_chk (
    input logic       clk,
    input logic       rst,
    input logic       busy,
    input logic [3:0] gnt,
    input logic [1:0] sel,
    input logic [3:0] in_ready
);
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_busy:    assert property (@(posedge clk) disable iff (rst) ((gnt != 4'b0000) == busy));
    a_ready_one:   assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
    a_sel_match:   assert property (@(posedge clk) disable iff (rst)
                                    (!busy || (gnt == (4'b0001 << sel))));
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, bursts, rotation, early release,
// backpressure and reset mid-burst, each with hand-derived expectations.
module tb_mux4_rr_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Starting in a cycle where requester idx should hold the grant, counts transfers
    // until the grant drops, then checks the bubble cycle.
    task automatic run_grant(input logic [1:0] idx, input int exp_xfers, input string name);
        logic [3:0] exp_gnt;
        int xfers;
        int cyc;
        exp_gnt = 4'b0001 << idx;
        xfers = 0;
        cyc = 0;
        checks++;
        if (bus.gnt !== exp_gnt || bus.sel !== idx) begin
            errors++;
            $display("FAIL %s_grant: gnt=%b sel=%0d, required gnt=%b sel=%0d",
                     name, bus.gnt, bus.sel, exp_gnt, idx);
        end
        while (bus.gnt === exp_gnt && cyc < 40) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xfers++;
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 40) begin
            errors++;
            $display("FAIL %s_timeout: grant held %0d cycles, required release", name, cyc);
        end
        checks++;
        if (xfers != exp_xfers) begin
            errors++;
            $display("FAIL %s_xfers: got %0d transfers, required %0d", name, xfers, exp_xfers);
        end
        checks++;
        if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_bubble: gnt=%b out_valid=%b, required 0000/0",
                     name, bus.gnt, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle: gnt=%b out_valid=%b in_ready=%b, required 0000/0/0000",
                         bus.gnt, bus.out_valid, bus.in_ready);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b sel=%0d, required 0001/0", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        bus.in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.out_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: out_data=%h, required a5", bus.out_data);
        end
        run_grant(2'd2, 4, "single");
        checks++;
        if (bus.out_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_bubble_data: out_data=%h, required a5", bus.out_data);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
            errors++;
            $display("FAIL single_regrant: gnt=%b sel=%0d, required 0100/2", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b1111;
        tick();
        for (int g = 0; g < 4; g++) begin
            run_grant(2'(g), 4, "rotation");
            tick();
        end
        checks++;
        if (bus.gnt !== 4'b0001 || bus.out_data !== 8'h11) begin
            errors++;
            $display("FAIL rotation_wrap: gnt=%b out_data=%h, required 0001/11",
                     bus.gnt, bus.out_data);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b1011;
        tick();
        tick();
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL early_held: gnt=%b, required 1000", bus.gnt);
        end
        bus.req = 4'b0011;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL early_drop: out_valid=%b in_ready=%b, required 0/1000",
                     bus.out_valid, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL early_release: gnt=%b, required 0000", bus.gnt);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL early_wrap: gnt=%b sel=%0d, required 0001/0", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0010 || bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_stall: gnt=%b in_ready=%b out_valid=%b, required 0010/0000/1",
                         bus.gnt, bus.in_ready, bus.out_valid);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL backpressure_resume: in_ready=%b, required 0010", bus.in_ready);
        end
        run_grant(2'd1, 3, "backpressure");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: gnt=%b out_valid=%b, required 0000/0",
                     bus.gnt, bus.out_valid);
        end
        rst = 1'b0;
        tick();
        run_grant(2'd2, 4, "midreset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.out_ready = 1'b1;
        bus.in_data = '0;
        test_reset();
        test_single_burst();
        test_rotation();
        test_early_release();
        test_backpressure();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexed output channel among four requesters.
- Owns the mux select: it grants one requester at a time and steers that requester's data to the output.
- Uses a valid/ready handshake with a per-grant burst limit.
- Sits in front of a single downstream consumer that must be time-shared by four sources.

Parameters:
- WIDTH, 8: data width per requester.
- MAX_BURST, 4: maximum transfers per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  request per requester; req[i] high = requester i has data on in_data[i].
- in_data  input  4*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-requester accept; in_ready[i] = gnt[i] & out_ready.
- gnt  output  4  registered one-hot grant, or all zero.
- sel  output  2  registered mux select, equal to the index of the granted requester.
- out_valid  output  1  output data valid.
- out_data  output  WIDTH  muxed data, always in_data[sel].
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, ptr = 0, gnt = 0, sel = 0, burst count = 0.
  - Outputs: out_valid = 0, in_ready = 0.
  - Reset takes effect mid-burst as well; an in-flight grant is dropped with no completion.
- State IDLE:
  - gnt = 0 and out_valid = 0.
  - If any req bit is high at the edge, choose the first requester at or after ptr, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - Next cycle: gnt = onehot(winner), sel = winner, count = 0, state = BUSY. Request-to-grant latency is 1 cycle.
  - If req = 0, remain in IDLE; ptr is unchanged.
- State BUSY:
  - out_valid = req[sel] (combinational from the registered sel).
  - out_data = in_data[sel].
  - in_ready = gnt & {4{out_ready}}.
  - A transfer occurs in any cycle with out_valid && out_ready. On a transfer, count increments.
  - Release condition, sampled at the edge, is either:
    - req[sel] == 0, or
    - a transfer occurs with count == MAX_BURST-1.
  - On release: state = IDLE, gnt = 0, ptr = sel+1 mod 4, count = 0.
  - Otherwise gnt and sel hold. Non-granted requesters are ignored.
- Every release produces exactly one IDLE bubble cycle, so back-to-back grants are never adjacent.
- Flow control:
  - out_ready low stalls the burst: no transfer, no count change, grant held.
  - A stall never forces release; only req drop or burst exhaustion releases.
- Fairness:
  - ptr advances only on release, to the requester just after the one released.
  - With all four requesting continuously, service order is 0,1,2,3,0,… with MAX_BURST transfers each.
- Invariants:
  - gnt is one-hot or zero.
  - gnt != 0 exactly in BUSY.
  - in_ready has at most one bit set.
  - out_data is defined (in_data[sel]) even when out_valid = 0.
- Width rules:
  - count width is 8 bits.
  - ptr and sel are 2 bits with natural mod-4 wrap (3+1 = 0).

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with req = 4'b1111.
  - Required: gnt = 0, out_valid = 0, in_ready = 0 throughout.
  - After rst drops: gnt = 4'b0001 one cycle later, sel = 0.
- Single requester burst:
  - Stimulus: req = 4'b0100 held, out_ready = 1, in_data[2] = 8'hA5.
  - Required: gnt = 4'b0100, sel = 2, out_data = 8'hA5, exactly 4 transfers.
  - Then one IDLE cycle, then regrant to 2 (ptr = 3, search wraps to 2).
- Round-robin rotation:
  - Stimulus: req = 4'b1111 held, out_ready = 1.
  - Required: grant sequence 0,1,2,3,0 with 4 transfers each and a 1-cycle gap between grants.
- Early release and wrap-around:
  - Stimulus: grant 3 with req = 4'b1011; drop req[3] after 2 transfers.
  - Required: release after 2 transfers, ptr = 0, next gnt = 4'b0001.
- Backpressure:
  - Stimulus: grant 1; out_ready low for 3 cycles mid-burst.
  - Required: gnt stays 4'b0010, in_ready = 0, count frozen.
  - Burst completes with exactly 4 transfers total.
- Reset mid-burst:
  - Stimulus: assert rst in the 2nd transfer cycle of a grant to requester 2.
  - Required: next cycle gnt = 0, out_valid = 0.
  - After rst drops with req = 4'b0100: fresh grant with count = 0 and a full 4-transfer burst.
